// File: rtl/serial_pkg.sv
// Definitions shared by the serial link transmitter and the future receiver.
// Holds the frame FSM states, the default geometry and a counter-width helper.
package serial_pkg;

   localparam int DATA_W_DEFAULT       = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } serial_state_e;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and raises tick
// on the last cycle of every bit period.
module serial_baud_cnt
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial link transmitter: start bit 0, DATA_W data bits LSB first, stop bit 1,
// each held for CLKS_PER_BIT cycles; ready/valid handshake on the input side.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEFAULT,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int               IDX_W    = cnt_width(DATA_W);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

   serial_state_e     state;
   logic [DATA_W-1:0] shift;
   logic [IDX_W-1:0]  bit_idx;
   logic              tick;
   logic              clear;

   // Holding the counter clear in IDLE aligns every bit period to acceptance.
   assign clear = (state == IDLE);

   serial_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .tick (tick)
   );

   // tx_out, tx_ready and busy are flops updated with the state, so the line
   // never sees a combinational path from the inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         tx_out   <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  shift    <= tx_data;
                  bit_idx  <= '0;
                  state    <= START;
                  tx_out   <= 1'b0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state  <= DATA;
                  tx_out <= shift[0];
                  shift  <= shift >> 1;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     state  <= STOP;
                     tx_out <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     tx_out  <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state    <= IDLE;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               tx_out   <= 1'b1;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed scenarios plus random payloads,
// each frame compared cycle by cycle against an arithmetic frame model.
module tb_serial_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic          tx_out;
   logic          busy;

   logic          valid1;
   logic [DW-1:0] data1;
   logic          ready1;
   logic          out1;
   logic          busy1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx_out  (tx_out),
      .busy    (busy)
   );

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut_fast (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(valid1),
      .tx_data (data1),
      .tx_ready(ready1),
      .tx_out  (out1),
      .busy    (busy1)
   );

   // Line level at cycle idx of a frame (idx 0 = first cycle after acceptance).
   function automatic logic exp_bit(input logic [DW-1:0] d, input int idx, input int cpb);
      int p;
      p = idx / cpb;
      if (p == 0)       return 1'b0;
      else if (p <= DW) return d[p-1];
      else              return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out"},   32'(tx_out),   32'd1);
      check({tag, "_ready"}, 32'(tx_ready), 32'd1);
      check({tag, "_busy"},  32'(busy),     32'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (tx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(tx_ready), 32'd1);
   endtask

   // Offer one word; returns at the negedge of the first START cycle.
   task automatic send_word(input logic [DW-1:0] d);
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic check_frame(input logic [DW-1:0] d, input int ncyc, input bit noise);
      for (int i = 0; i < ncyc; i++) begin
         check($sformatf("bit_%02h_c%0d", d, i), 32'(tx_out), 32'(exp_bit(d, i, CPB)));
         check($sformatf("busy_%02h_c%0d", d, i), 32'(busy), 32'd1);
         check($sformatf("ready_%02h_c%0d", d, i), 32'(tx_ready), 32'd0);
         if (noise) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'hFF;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      int gap;

      reset    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      valid1   = 1'b1;
      data1    = 8'h5A;

      // Reset held 20 ns with valid offered: line stays idle.
      @(negedge clk);
      check_idle("rst_a");
      check("rst_fast_out", 32'(out1), 32'd1);
      @(negedge clk);
      check_idle("rst_b");
      check("rst_fast_ready", 32'(ready1), 32'd1);
      tx_valid = 1'b0;
      valid1   = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check_idle("post_rst");

      // Single frame 0xA5.
      send_word(8'hA5);
      check_frame(8'hA5, FRAME, 1'b0);
      check_idle("a5_end");

      // Back-to-back: valid held, data switched to 0xFF once 0x00 is in flight.
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      @(negedge clk);
      tx_data  = 8'hFF;
      check_frame(8'h00, FRAME, 1'b0);
      check_idle("b2b_gap");
      @(negedge clk);
      tx_valid = 1'b0;
      check_frame(8'hFF, FRAME, 1'b0);
      check_idle("b2b_end");

      // Input noise while busy must not disturb 0x3C or spawn a frame.
      send_word(8'h3C);
      check_frame(8'h3C, FRAME, 1'b1);
      tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle($sformatf("noise_idle%0d", i));
         @(negedge clk);
      end

      // Reset during data bit 3 of 0x55, then 0x81 offered at release.
      send_word(8'h55);
      check_frame(8'h55, 4 * CPB + 2, 1'b0);
      #2 reset = 1'b0;
      #1 check_idle("midrst_async");
      @(negedge clk);
      check_idle("midrst_hold");
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      reset    = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_frame(8'h81, FRAME, 1'b0);
      check_idle("r81_end");

      // Random payloads with random idle gaps.
      for (int k = 0; k < 5; k++) begin
         d   = 8'($urandom);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            check_idle($sformatf("rnd_gap%0d_%0d", k, g));
            @(negedge clk);
         end
         send_word(d);
         check_frame(d, FRAME, 1'b0);
         check_idle($sformatf("rnd_end%0d", k));
      end

      // One clock per bit: 0x96 gives 0,0,1,1,0,1,0,0,1,1.
      check("fast_ready", 32'(ready1), 32'd1);
      valid1 = 1'b1;
      data1  = 8'h96;
      @(negedge clk);
      valid1 = 1'b0;
      for (int i = 0; i < DW + 2; i++) begin
         check($sformatf("fast_bit%0d", i), 32'(out1), 32'(exp_bit(8'h96, i, 1)));
         check($sformatf("fast_busy%0d", i), 32'(busy1), 32'd1);
         @(negedge clk);
      end
      check("fast_end_out", 32'(out1), 32'd1);
      check("fast_end_ready", 32'(ready1), 32'd1);
      check("fast_end_busy", 32'(busy1), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 tx_valid  input  1  producer offers tx_data this cycle.
REQ-006 tx_data  input  DATA_W  payload word to serialize.
REQ-007 tx_ready  output  1  block can accept a word this cycle.
REQ-008 tx_out  output  1  serial line; idle level 1.
REQ-009 busy  output  1  frame in progress (START, DATA or STOP).

Function
REQ-010 The block SHALL be the transmit end of the team's serial link and emit frames of 1 start bit (0), DATA_W data bits sent LSB first, and 1 stop bit (1).
REQ-011 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-012 A transfer SHALL occur only on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be captured into an internal shift register on that edge.
REQ-013 tx_ready SHALL be 1 only in IDLE; busy SHALL equal NOT tx_ready.
REQ-014 On transfer, the FSM SHALL go IDLE->START, so tx_out is 0 from the cycle after acceptance.
REQ-015 Each of START, each data bit, and STOP SHALL hold tx_out constant for exactly CLKS_PER_BIT cycles, timed by a bit-period counter counting 0..CLKS_PER_BIT-1.
REQ-016 START->DATA, DATA->DATA (next bit) and DATA->STOP (after bit DATA_W-1) transitions SHALL occur when the bit-period counter reaches CLKS_PER_BIT-1.
REQ-017 STOP->IDLE SHALL occur after the STOP bit period completes; frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles.
REQ-018 Back-to-back words SHALL be separated by at least one IDLE cycle (tx_out=1); a valid word held during a frame SHALL be accepted on the first IDLE cycle.
REQ-019 tx_valid and tx_data changes while busy=1 SHALL have no effect on the frame in flight.
REQ-020 tx_out SHALL be driven directly from a register (glitch-free, no combinational path from inputs).
REQ-021 Bit-index counter width SHALL be ceil(log2(DATA_W)) (minimum 1); bit-period counter width SHALL be ceil(log2(CLKS_PER_BIT)) (minimum 1); neither SHALL wrap mid-frame.
REQ-022 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle.

Reset
REQ-023 reset=0 SHALL immediately, without a clock edge, force the state to IDLE, tx_out=1, tx_ready=1, busy=0, and both counters and the shift register to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no further bits; after reset release, the first accepted word SHALL start a complete new frame.
REQ-025 A tx_valid present on the first edge after reset release SHALL be accepted.

Structure
REQ-026 The state enumeration and the default values of DATA_W and CLKS_PER_BIT SHALL live in the shared package serial_pkg, which the future receiver will also use.
REQ-027 The bit-period counter SHALL be a sub-module serial_baud_cnt (ports: clk, reset, clear, tick) that asserts tick on the last cycle of each bit period; all other logic SHALL live in serial_tx.

Verification
REQ-028 Reset: hold reset=0 for 20 ns with tx_valid=1 -> tx_out=1, tx_ready=1, busy=0 throughout; no frame starts.
REQ-029 Single frame, DATA_W=8, CLKS_PER_BIT=4: send 0xA5 -> tx_out=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy=1 for 40 cycles.
REQ-030 Back-to-back: hold tx_valid=1 with 0x00 then 0xFF -> exactly one idle cycle (tx_out=1, tx_ready=1) between the frames; both payloads are correct.
REQ-031 Ignore while busy: during 0x3C frame, drive tx_data=0xFF with tx_valid pulsing -> transmitted bits match 0x3C; no extra frame results.
REQ-032 Mid-frame reset: assert reset=0 during data bit 3 of 0x55 -> tx_out=1 immediately; after release, 0x81 is sent as a complete, correct frame.
REQ-033 CLKS_PER_BIT=1: send 0x96 -> 10-cycle frame 0,0,1,1,0,1,0,0,1,1 (start, LSB..MSB, stop).
